// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the single write port (WE3/A3/WD3) of the 32x32 register
// file. It merges single-cycle ALU results with variable-latency load
// responses buffered in a small FIFO, and keeps a per-register pending-load
// scoreboard so that decode can stall on load-use hazards.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   alu_we/alu_rd/alu_wd          ALU write-back request
//   alu_stall                     ALU request not consumed this cycle
//   ld_issue/ld_issue_rd          load issued (marks destination busy)
//   ld_valid/ld_rd/ld_data        load response; ld_ready = FIFO not full
//   WE3/A3/WD3                    registered register-file write port
//   busy                          pending-load scoreboard, bit r = xr
//   err                           sticky protocol-violation flag
//
// Handshakes: a load response transfers on an edge where ld_valid && ld_ready.
// An ALU request (alu_we) is consumed on any edge where alu_stall is 0; while
// alu_stall is 1 the producer holds alu_we/alu_rd/alu_wd unchanged.
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wd,
  output logic        alu_stall,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic [31:0] busy,
  output logic        err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  // Load-response FIFO
  logic [4:0]    r_q_rd   [FIFO_DEPTH];
  logic [31:0]   r_q_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;

  // Output / scoreboard state
  logic          r_we;
  logic [4:0]    r_a3;
  logic [31:0]   r_wd;
  logic          r_wb_ld;   // current WE3 pulse came from the FIFO
  logic [31:0]   r_busy;
  logic          r_err;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_alu_real;
  logic          w_alu_win;
  logic          w_clr;
  logic [31:0]   w_busy_nxt;
  logic          w_err_evt;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;

  assign w_empty    = (r_count == '0);
  // ld_ready looks only at count: no push-through when full, even on a pop.
  assign ld_ready   = (r_count != FULL_C);
  assign w_push     = ld_valid && ld_ready;
  assign w_alu_real = alu_we && (alu_rd != 5'd0);
  assign alu_stall  = (r_starve == STARVE_C) && !w_empty && w_alu_real;
  assign w_alu_win  = w_alu_real && !alu_stall;
  // An ALU write to x0 is dropped and does not block the FIFO.
  assign w_pop      = !w_alu_win && !w_empty;
  assign w_head_rd   = r_q_rd[r_rptr];
  assign w_head_data = r_q_data[r_rptr];

  // Scoreboard: clear on the edge the FIFO-sourced write commits; set wins.
  assign w_clr = r_we && r_wb_ld;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[r_a3] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) w_busy_nxt[ld_issue_rd] = 1'b1;
  end

  always_comb begin
    w_err_evt = 1'b0;
    if (ld_issue && r_busy[ld_issue_rd] && !(w_clr && (r_a3 == ld_issue_rd)))
      w_err_evt = 1'b1;
    if (w_push && (ld_rd != 5'd0) && !r_busy[ld_rd])
      w_err_evt = 1'b1;
  end

  // FIFO storage needs no reset; entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr]   <= ld_rd;
      r_q_data[r_wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_a3     <= 5'd0;
      r_wd     <= 32'd0;
      r_wb_ld  <= 1'b0;
      r_busy   <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Starvation is counted on the pre-edge FIFO state.
      if (w_empty || w_pop)          r_starve <= '0;
      else if (r_starve != STARVE_C) r_starve <= r_starve + SW'(1);

      if (w_alu_win) begin
        r_we    <= 1'b1;
        r_a3    <= alu_rd;
        r_wd    <= alu_wd;
        r_wb_ld <= 1'b0;
      end else if (w_pop && (w_head_rd != 5'd0)) begin
        r_we    <= 1'b1;
        r_a3    <= w_head_rd;
        r_wd    <= w_head_data;
        r_wb_ld <= 1'b1;
      end else begin
        // Covers the idle case and a discarded x0 response.
        r_we    <= 1'b0;
        r_wb_ld <= 1'b0;
      end

      r_busy <= w_busy_nxt;
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign WE3  = r_we;
  assign A3   = r_a3;
  assign WD3  = r_wd;
  assign busy = r_busy;
  assign err  = r_err;

endmodule
